// File: rtl/word_shift_pipeline_if.sv
// word_shift_pipeline_if: control, data and status bundle for word_shift_pipeline
interface word_shift_pipeline_if #(parameter int WIDTH = 16, DEPTH = 8, SEL_W = 3, CNT_W = 4);
  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       shift_in;
  logic                   load;
  logic [DEPTH*WIDTH-1:0] load_data;
  logic                   clr;
  logic [SEL_W-1:0]       tap_sel;
  logic [DEPTH*WIDTH-1:0] stages;
  logic [WIDTH-1:0]       tap_out;
  logic [WIDTH-1:0]       shift_out;
  logic                   shift_out_valid;
  logic [CNT_W-1:0]       fill_count;
  logic                   full;
  logic                   empty;
  modport master (
    output en, mode, shift_in, load, load_data, clr, tap_sel,
    input  stages, tap_out, shift_out, shift_out_valid, fill_count, full, empty
  );
  modport slave (
    input  en, mode, shift_in, load, load_data, clr, tap_sel,
    output stages, tap_out, shift_out, shift_out_valid, fill_count, full, empty
  );
endinterface

// File: rtl/word_shift_pipeline.sv
// word_shift_pipeline: bidirectional word shift/rotate pipeline with valid map, fill count and tap
module word_shift_pipeline #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  word_shift_pipeline_if.slave bus
);
  localparam int N = DEPTH * WIDTH;
  logic [N-1:0]       st, st_n;
  logic [DEPTH-1:0]   v, v_n;
  logic [WIDTH-1:0]   so, so_n;
  logic               sov, sov_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               act, up, dn, rot;
  always_comb begin
    act = !bus.clr && !bus.load && bus.en;
    up = act && bus.mode == 2'b01;
    dn = act && bus.mode == 2'b10;
    rot = act && bus.mode == 2'b11;
    // stage 0 sits in the low word, so "up" is a left shift of the flat vector
    st_n = bus.clr ? '0 : bus.load ? bus.load_data :
           up ? {st[N-WIDTH-1:0], bus.shift_in} :
           dn ? {bus.shift_in, st[N-1:WIDTH]} :
           rot ? {st[N-WIDTH-1:0], st[N-1 -: WIDTH]} : st;
    v_n = bus.clr ? '0 : bus.load ? '1 :
          up ? {v[DEPTH-2:0], 1'b1} :
          dn ? {1'b1, v[DEPTH-1:1]} :
          rot ? {v[DEPTH-2:0], v[DEPTH-1]} : v;
    so_n = up ? st[N-1 -: WIDTH] : dn ? st[WIDTH-1:0] : so;
    sov_n = up ? v[DEPTH-1] : dn ? v[0] : 1'b0;
    cnt_n = '0;
    for (int i = 0; i < DEPTH; i++) cnt_n = cnt_n + CNT_W'(v_n[i]);
    bus.tap_out = '0;
    for (int i = 0; i < DEPTH; i++) if (bus.tap_sel == SEL_W'(i)) bus.tap_out = st[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
      v <= '0;
      so <= '0;
      sov <= 1'b0;
      cnt <= '0;
    end else begin
      st <= st_n;
      v <= v_n;
      so <= so_n;
      sov <= sov_n;
      cnt <= cnt_n;
    end
  end
  assign bus.stages = st;
  assign bus.shift_out = so;
  assign bus.shift_out_valid = sov;
  assign bus.fill_count = cnt;
  assign bus.full = cnt == CNT_W'(DEPTH);
  assign bus.empty = cnt == '0;
endmodule

// File: tb/tb_word_shift_pipeline.sv
// tb_word_shift_pipeline: directed test-plan scenarios plus randomized run against a queue model
module tb_word_shift_pipeline;
  localparam int W = 16, D = 8, S = 3, C = 4;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, fails = 0;
  logic [W-1:0] mq[$];
  bit vq[$];
  logic [W-1:0] mso;
  bit msov;

  word_shift_pipeline_if #(.WIDTH(W), .DEPTH(D), .SEL_W(S), .CNT_W(C)) bus ();
  word_shift_pipeline #(.WIDTH(W), .DEPTH(D), .SEL_W(S), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic idle();
    bus.en = 0; bus.mode = 0; bus.shift_in = 0; bus.load = 0; bus.clr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    idle();
    @(negedge clk); rst = 1; #2; rst = 0;
  endtask

  // queue index k is stage k; shifts are push/pop at the ends
  function automatic void model_edge();
    if (bus.clr) begin
      foreach (mq[i]) begin mq[i] = 0; vq[i] = 0; end
      msov = 0;
    end else if (bus.load) begin
      foreach (mq[i]) begin mq[i] = bus.load_data[i*W +: W]; vq[i] = 1; end
      msov = 0;
    end else if (bus.en && bus.mode == 2'b01) begin
      mso = mq.pop_back(); msov = vq.pop_back();
      mq.push_front(bus.shift_in); vq.push_front(1);
    end else if (bus.en && bus.mode == 2'b10) begin
      mso = mq.pop_front(); msov = vq.pop_front();
      mq.push_back(bus.shift_in); vq.push_back(1);
    end else if (bus.en && bus.mode == 2'b11) begin
      mq.push_front(mq.pop_back()); vq.push_front(vq.pop_back());
      msov = 0;
    end else msov = 0;
  endfunction

  task automatic test_reset();
    idle(); bus.tap_sel = 0; bus.load_data = 0;
    rst = 1; #12;
    checks++; if (bus.stages !== '0) begin fails++; $display("FAIL reset_stages got %h want 0", bus.stages); end
    checks++; if (bus.fill_count !== 0) begin fails++; $display("FAIL reset_fill got %0d want 0", bus.fill_count); end
    checks++; if (bus.full !== 0 || bus.empty !== 1) begin fails++; $display("FAIL reset_flags got full=%b empty=%b want 0/1", bus.full, bus.empty); end
    checks++; if (bus.shift_out !== 0 || bus.shift_out_valid !== 0) begin fails++; $display("FAIL reset_out got %h/%b want 0/0", bus.shift_out, bus.shift_out_valid); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      bus.en = 1; bus.mode = 2'b01; bus.shift_in = W'(k); step();
      checks++; if (bus.shift_out_valid !== 0) begin fails++; $display("FAIL fill_sov step %0d got %b want 0", k, bus.shift_out_valid); end
    end
    checks++; if (bus.stages[0 +: W] !== 16'h0008) begin fails++; $display("FAIL fill_stage0 got %h want 0008", bus.stages[0 +: W]); end
    checks++; if (bus.stages[7*W +: W] !== 16'h0001) begin fails++; $display("FAIL fill_stage7 got %h want 0001", bus.stages[7*W +: W]); end
    checks++; if (bus.fill_count !== 8 || bus.full !== 1) begin fails++; $display("FAIL fill_count got %0d full=%b want 8/1", bus.fill_count, bus.full); end
  endtask

  task automatic test_overflow();
    logic [D*W-1:0] exp;
    bus.shift_in = 16'h0009; step();
    checks++; if (bus.shift_out !== 16'h0001 || bus.shift_out_valid !== 1) begin fails++; $display("FAIL ovf_eject got %h/%b want 0001/1", bus.shift_out, bus.shift_out_valid); end
    checks++; if (bus.fill_count !== 8) begin fails++; $display("FAIL ovf_fill got %0d want 8", bus.fill_count); end
    bus.en = 0; step();
    for (int i = 0; i < D; i++) exp[i*W +: W] = W'(9 - i);
    checks++; if (bus.shift_out_valid !== 0) begin fails++; $display("FAIL hold_sov got %b want 0", bus.shift_out_valid); end
    checks++; if (bus.stages !== exp) begin fails++; $display("FAIL hold_stages got %h want %h", bus.stages, exp); end
  endtask

  task automatic test_partial_down();
    pulse_rst();
    for (int k = 0; k < 3; k++) begin bus.en = 1; bus.mode = 2'b01; bus.shift_in = 16'hAAAA; step(); end
    checks++; if (bus.fill_count !== 3) begin fails++; $display("FAIL part_fill got %0d want 3", bus.fill_count); end
    checks++; if (bus.stages[2*W +: W] !== 16'hAAAA || bus.stages[3*W +: W] !== 0) begin fails++; $display("FAIL part_stages got %h want s2=AAAA s3=0", bus.stages); end
    for (int k = 0; k < 3; k++) begin
      bus.mode = 2'b10; bus.shift_in = 16'h5555; step();
      checks++; if (bus.shift_out !== 16'hAAAA || bus.shift_out_valid !== 1) begin fails++; $display("FAIL down_eject %0d got %h/%b want AAAA/1", k, bus.shift_out, bus.shift_out_valid); end
    end
    checks++; if (bus.fill_count !== 3) begin fails++; $display("FAIL down_fill got %0d want 3", bus.fill_count); end
    checks++; if (bus.stages[0 +: W] !== 0 || bus.stages[5*W +: W] !== 16'h5555) begin fails++; $display("FAIL down_stages got %h want s0=0 s5=5555", bus.stages); end
  endtask

  task automatic test_rotate();
    logic [D*W-1:0] ld;
    for (int i = 0; i < D; i++) ld[i*W +: W] = W'(16'h1000 + i);
    idle(); bus.load = 1; bus.load_data = ld; step(); bus.load = 0;
    checks++; if (bus.stages !== ld || bus.fill_count !== 8) begin fails++; $display("FAIL load got %h fill %0d want %h fill 8", bus.stages, bus.fill_count, ld); end
    bus.en = 1; bus.mode = 2'b11; bus.shift_in = 16'hFFFF; step();
    checks++; if (bus.stages[0 +: W] !== 16'h1007) begin fails++; $display("FAIL rot_stage0 got %h want 1007", bus.stages[0 +: W]); end
    bus.tap_sel = 3'd1; #1;
    checks++; if (bus.tap_out !== 16'h1000) begin fails++; $display("FAIL tap1 got %h want 1000", bus.tap_out); end
    bus.tap_sel = 3'd7; #1;
    checks++; if (bus.tap_out !== 16'h1006) begin fails++; $display("FAIL tap7 got %h want 1006", bus.tap_out); end
    for (int k = 0; k < 7; k++) step();
    checks++; if (bus.stages !== ld) begin fails++; $display("FAIL rot_full got %h want %h", bus.stages, ld); end
    checks++; if (bus.shift_out_valid !== 0 || bus.fill_count !== 8) begin fails++; $display("FAIL rot_status got sov=%b fill=%0d want 0/8", bus.shift_out_valid, bus.fill_count); end
  endtask

  task automatic test_priority();
    bus.clr = 1; bus.load = 1; bus.en = 1; bus.mode = 2'b01; step();
    checks++; if (bus.stages !== '0 || bus.fill_count !== 0 || bus.empty !== 1) begin fails++; $display("FAIL prio_clr got fill=%0d empty=%b want 0/1", bus.fill_count, bus.empty); end
    idle(); bus.load = 1; step(); bus.load = 0;
    checks++; if (bus.fill_count !== 8 || bus.full !== 1) begin fails++; $display("FAIL prio_load got fill=%0d full=%b want 8/1", bus.fill_count, bus.full); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #1 rst = 1; #1;
    checks++; if (bus.stages !== '0 || bus.fill_count !== 0) begin fails++; $display("FAIL arst_state got fill=%0d want 0", bus.fill_count); end
    checks++; if (bus.empty !== 1 || bus.full !== 0 || bus.shift_out_valid !== 0 || bus.shift_out !== 0) begin fails++; $display("FAIL arst_flags got e=%b f=%b sov=%b so=%h want 1/0/0/0", bus.empty, bus.full, bus.shift_out_valid, bus.shift_out); end
    rst = 0;
    bus.en = 1; bus.mode = 2'b01; bus.shift_in = 16'h1234; step();
    checks++; if (bus.fill_count !== 1 || bus.stages[0 +: W] !== 16'h1234) begin fails++; $display("FAIL arst_resume got fill=%0d s0=%h want 1/1234", bus.fill_count, bus.stages[0 +: W]); end
  endtask

  task automatic test_random();
    logic [D*W-1:0] exp;
    int pop;
    pulse_rst();
    mq.delete(); vq.delete();
    for (int i = 0; i < D; i++) begin mq.push_back(0); vq.push_back(0); end
    mso = 0; msov = 0;
    for (int n = 0; n < 400; n++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      bus.mode = 2'($urandom_range(0, 3));
      bus.shift_in = W'($urandom);
      bus.load = ($urandom_range(0, 9) == 0);
      bus.clr = ($urandom_range(0, 15) == 0);
      bus.load_data = {$urandom, $urandom, $urandom, $urandom};
      bus.tap_sel = S'($urandom);
      model_edge();
      step();
      pop = 0;
      for (int i = 0; i < D; i++) begin exp[i*W +: W] = mq[i]; pop += int'(vq[i]); end
      checks++; if (bus.stages !== exp) begin fails++; $display("FAIL rnd_stages %0d got %h want %h", n, bus.stages, exp); end
      checks++; if (bus.fill_count !== C'(pop) || bus.full !== (pop == D) || bus.empty !== (pop == 0)) begin fails++; $display("FAIL rnd_fill %0d got %0d f=%b e=%b want %0d", n, bus.fill_count, bus.full, bus.empty, pop); end
      checks++; if (bus.shift_out !== mso || bus.shift_out_valid !== msov) begin fails++; $display("FAIL rnd_out %0d got %h/%b want %h/%b", n, bus.shift_out, bus.shift_out_valid, mso, msov); end
      checks++; if (bus.tap_out !== mq[bus.tap_sel]) begin fails++; $display("FAIL rnd_tap %0d got %h want %h", n, bus.tap_out, mq[bus.tap_sel]); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_partial_down();
    test_rotate();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/word_shift_pipeline.md
Name: word_shift_pipeline

Overview:
Parametrised multi-word shift pipeline that generalises the fixed 16-bit x 8-stage shifter.
- Full-word data path of WIDTH bits per stage, DEPTH stages.
- Bidirectional shift, rotate, parallel load, synchronous clear and a per-stage valid map with fill tracking.
- Used as a programmable delay line / word FIFO-like staging buffer in the datapath labs, with a selectable tap for intermediate-stage observation.

Parameters:
WIDTH, 16, bits per stage word.
DEPTH, 8, number of stages; legal range 2..64.
SEL_W, 3, width of tap_sel; must satisfy 2**SEL_W >= DEPTH.
CNT_W, 4, width of fill_count; must hold the value DEPTH.

Ports:
clk  in  1  rising-edge clock; the only clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  advance enable for shift/rotate modes.
mode  in  2  00 hold, 01 shift up, 10 shift down, 11 rotate up.
shift_in  in  WIDTH  word entering the pipeline on a shift.
load  in  1  parallel load strobe.
load_data  in  DEPTH*WIDTH  stage i is taken from bits [i*WIDTH +: WIDTH].
clr  in  1  synchronous clear of data and valid map.
tap_sel  in  SEL_W  stage index driven onto tap_out.
stages  out  DEPTH*WIDTH  registered contents; stage i is at [i*WIDTH +: WIDTH].
tap_out  out  WIDTH  combinational copy of stage tap_sel.
shift_out  out  WIDTH  registered word ejected by the last shift.
shift_out_valid  out  1  registered; high for one cycle when shift_out holds an ejected valid word.
fill_count  out  CNT_W  number of valid stages.
full  out  1  all DEPTH stages valid.
empty  out  1  no stage valid.

Behaviour:
- Reset (rst=1, asynchronous): all stages=0, valid map=0, shift_out=0, shift_out_valid=0, fill_count=0, full=0, empty=1.
- Priority per cycle is clr > load > (en and mode). Only one action occurs per edge.
- clr: all stages=0, valid=0, shift_out_valid=0, shift_out unchanged.
- load: stage[i]=load_data slice i and valid[i]=1 for all i. shift_out_valid=0.
- en=0 or mode=00: everything holds; shift_out_valid=0 on the next edge.
- mode=01 (shift up):
  - stage[0]<=shift_in, valid[0]<=1.
  - stage[i]<=stage[i-1] and valid[i]<=valid[i-1].
  - shift_out<=old stage[DEPTH-1]; shift_out_valid<=old valid[DEPTH-1].
- mode=10 (shift down): mirror of shift up.
  - stage[DEPTH-1]<=shift_in, valid[DEPTH-1]<=1.
  - stage[i]<=stage[i+1] and valid[i]<=valid[i+1].
  - Ejected word is old stage[0] with old valid[0].
- mode=11 (rotate up):
  - stage[0]<=old stage[DEPTH-1]; valid rotates identically.
  - shift_in is ignored; shift_out_valid=0; fill_count unchanged.
- Latency: a word entering on edge N appears at stage k after edge N+k for shift up. It is ejected on edge N+DEPTH, with shift_out_valid high for the cycle after that edge.
- fill_count = population count of the valid map, registered alongside it.
  - It saturates naturally at DEPTH: shifting while full keeps it at DEPTH and produces shift_out_valid=1 every edge.
  - full = (fill_count==DEPTH); empty = (fill_count==0).
- tap_out: tap_sel >= DEPTH drives all zeros. There is no valid qualification on tap_out.
- Mode changes take effect on the next enabled edge with no bubble. A shift up then shift down restores the original stage contents except the ejected/inserted word.
- Reset asserted mid-operation clears state immediately, without waiting for clk. Deassertion resumes on the first following edge.

Test Plan:
- Fill: WIDTH=16, DEPTH=8; after reset, shift up 0x0001..0x0008 on 8 edges -> stage0=0x0008, stage7=0x0001, fill_count=8, full=1, shift_out_valid=0 throughout.
- Overflow: continue with 0x0009 -> shift_out=0x0001, shift_out_valid=1 for one cycle, fill_count stays 8; en=0 next cycle -> shift_out_valid=0, stages unchanged.
- Partial and shift down:
  - From reset, shift up 0xAAAA three times -> fill_count=3, valid in stages 0..2.
  - Then shift down 3 times with shift_in=0x5555 -> ejects 0xAAAA three times with shift_out_valid=1; final fill_count=3 (stages 5..7 valid, stage 0 data 0x0000 invalid).
- Rotate: load stages i=0x1000+i, rotate 8 edges -> stages return to 0x1000+i. After 1 edge, stage0=0x1007 and tap_sel=1 shows 0x1000. tap_sel=3'd7 shows the stage-7 value.
- Priority: assert clr, load and en/mode=01 on the same edge -> all stages 0, fill_count=0, empty=1. Next edge load alone -> fill_count=8.
- Async reset: pulse rst between clock edges while full -> all outputs at reset values before the next clk edge; first shift after release gives fill_count=1.
